// File: rtl/dls_nmr_checker_if.sv
// Bus bundle between the redundant peripheral copies, the lockstep checker and the system.
// Self-test injection signals exist only when DLS_ERR_INJECT_EN is defined.
interface dls_nmr_checker_if #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned W     = 43,
  parameter int unsigned CNT_W = 8
);
  logic [NCH*W-1:0] ch_in;
  logic             ch_valid;
  logic             err_clear;
`ifdef DLS_ERR_INJECT_EN
  logic             inj_en;
  logic [W-1:0]     inj_mask;
`endif
  logic [W-1:0]     voted_out;
  logic             mismatch;
  logic             DLS_ERROR;
  logic [NCH-1:0]   fault_chan;
  logic [CNT_W-1:0] err_count;
  logic [1:0]       fsm_state;

  modport master (
`ifdef DLS_ERR_INJECT_EN
    output inj_en, inj_mask,
`endif
    output ch_in, ch_valid, err_clear,
    input  voted_out, mismatch, DLS_ERROR, fault_chan, err_count, fsm_state
  );

  modport slave (
`ifdef DLS_ERR_INJECT_EN
    input  inj_en, inj_mask,
`endif
    input  ch_in, ch_valid, err_clear,
    output voted_out, mismatch, DLS_ERROR, fault_chan, err_count, fsm_state
  );
endinterface

// File: rtl/dls_nmr_checker.sv
// 2- or 3-channel lockstep checker: persistence-filtered fault detection, sticky status, TMR vote.
// Optional checker self-test XOR on the last channel: define DLS_ERR_INJECT_EN.
module dls_nmr_checker #(
  parameter int unsigned  NCH      = 2,
  parameter int unsigned  W        = 43,
  parameter logic [W-1:0] CMP_MASK = {W{1'b1}},
  parameter int unsigned  FILTER   = 1,
  parameter int unsigned  CNT_W    = 8
) (
  input logic              HCLK,
  input logic              HRESETn,
  dls_nmr_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_SUSPECT = 2'b01,
    ST_FAULT   = 2'b10
  } state_t;

  localparam logic [7:0] FILTER_C = 8'(FILTER);

  if (NCH != 2 && NCH != 3) begin : g_bad_nch
    $error("dls_nmr_checker: NCH must be 2 or 3");
  end
  if (FILTER < 1 || FILTER > 255) begin : g_bad_filter
    $error("dls_nmr_checker: FILTER must be in 1..255");
  end

  logic [W-1:0]   ch [NCH];
  logic [W-1:0]   voted;
  logic [NCH-1:0] faulty;
  logic           any_diff;
  logic           raw;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch[i] = bus.ch_in[i*W +: W];
    end
`ifdef DLS_ERR_INJECT_EN
    if (bus.inj_en) begin
      ch[NCH-1] = ch[NCH-1] ^ bus.inj_mask;
    end
`endif
  end

  if (NCH == 3) begin : g_tmr
    logic d01, d02, d12;
    assign d01      = |((ch[0] ^ ch[1]) & CMP_MASK);
    assign d02      = |((ch[0] ^ ch[2]) & CMP_MASK);
    assign d12      = |((ch[1] ^ ch[2]) & CMP_MASK);
    assign any_diff = d01 | d02 | d12;
    // The vote covers every bit; the mask only narrows what counts as a disagreement.
    assign voted    = (ch[0] & ch[1]) | (ch[0] & ch[2]) | (ch[1] & ch[2]);
    assign faulty   = (d01 & d02 & d12) ? 3'b111
                    : {|((ch[2] ^ voted) & CMP_MASK),
                       |((ch[1] ^ voted) & CMP_MASK),
                       |((ch[0] ^ voted) & CMP_MASK)};
  end else begin : g_dmr
    // Two copies cannot arbitrate, so both are blamed.
    assign any_diff = |((ch[0] ^ ch[1]) & CMP_MASK);
    assign voted    = ch[0];
    assign faulty   = '1;
  end

  assign raw = bus.ch_valid & any_diff;

  state_t     state, state_nxt;
  logic [7:0] pcnt, pcnt_nxt;
  logic       enter_fault;

  always_comb begin
    state_nxt   = state;
    pcnt_nxt    = pcnt;
    enter_fault = 1'b0;
    case (state)
      ST_OK: begin
        if (raw) begin
          if (FILTER == 1) begin
            state_nxt   = ST_FAULT;
            enter_fault = 1'b1;
          end else begin
            state_nxt = ST_SUSPECT;
            pcnt_nxt  = 8'd1;
          end
        end
      end
      ST_SUSPECT: begin
        if (raw) begin
          pcnt_nxt = pcnt + 8'd1;
          if (pcnt_nxt == FILTER_C) begin
            state_nxt   = ST_FAULT;
            enter_fault = 1'b1;
          end
        end else if (bus.ch_valid) begin
          state_nxt = ST_OK;
          pcnt_nxt  = 8'd0;
        end
      end
      ST_FAULT: begin
        if (bus.ch_valid && !raw) begin
          state_nxt = ST_OK;
          pcnt_nxt  = 8'd0;
        end
      end
      default: begin
        state_nxt = ST_OK;
        pcnt_nxt  = 8'd0;
      end
    endcase
    // A clear beats a simultaneous confirmation; that event is dropped entirely.
    if (bus.err_clear) begin
      state_nxt   = ST_OK;
      pcnt_nxt    = 8'd0;
      enter_fault = 1'b0;
    end
  end

  logic [W-1:0]     voted_q;
  logic             mismatch_q;
  logic             err_q;
  logic [NCH-1:0]   fchan_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= ST_OK;
      pcnt       <= 8'd0;
      voted_q    <= '0;
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
      fchan_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state      <= state_nxt;
      pcnt       <= pcnt_nxt;
      voted_q    <= voted;
      mismatch_q <= raw;
      if (bus.err_clear) begin
        err_q   <= 1'b0;
        fchan_q <= '0;
        cnt_q   <= '0;
      end else if (enter_fault) begin
        err_q   <= 1'b1;
        fchan_q <= fchan_q | faulty;
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.voted_out  = voted_q;
  assign bus.mismatch   = mismatch_q;
  assign bus.DLS_ERROR  = err_q;
  assign bus.fault_chan = fchan_q;
  assign bus.err_count  = cnt_q;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_dls_nmr_checker.sv
// Self-checking bench: four checker configurations share one stimulus stream and are compared
// each cycle against a behavioural model; directed steps then random traffic.
module tb_dls_nmr_checker;

  localparam int W = 43;
  localparam logic [W-1:0] MASK_ALL   = {W{1'b1}};
  localparam logic [W-1:0] MASK_NO42  = {1'b0, {(W-1){1'b1}}};

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  // d0: NCH2/F1/C8  d1: NCH3/F3/C8  d2: NCH2/F1/C2  d3: NCH3/F3/C8, bit 42 not compared
  dls_nmr_checker_if #(.NCH(2), .W(W), .CNT_W(8)) if_a ();
  dls_nmr_checker_if #(.NCH(3), .W(W), .CNT_W(8)) if_b ();
  dls_nmr_checker_if #(.NCH(2), .W(W), .CNT_W(2)) if_s ();
  dls_nmr_checker_if #(.NCH(3), .W(W), .CNT_W(8)) if_m ();

  dls_nmr_checker #(.NCH(2), .W(W), .CMP_MASK(MASK_ALL), .FILTER(1), .CNT_W(8))
    dut_a (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if_a));
  dls_nmr_checker #(.NCH(3), .W(W), .CMP_MASK(MASK_ALL), .FILTER(3), .CNT_W(8))
    dut_b (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if_b));
  dls_nmr_checker #(.NCH(2), .W(W), .CMP_MASK(MASK_ALL), .FILTER(1), .CNT_W(2))
    dut_s (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if_s));
  dls_nmr_checker #(.NCH(3), .W(W), .CMP_MASK(MASK_NO42), .FILTER(3), .CNT_W(8))
    dut_m (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if_m));

  int unsigned    nch_c  [4] = '{2, 3, 2, 3};
  int unsigned    filt_c [4] = '{1, 3, 1, 3};
  int unsigned    cntw_c [4] = '{8, 8, 2, 8};
  logic [W-1:0]   mask_c [4] = '{MASK_ALL, MASK_ALL, MASK_ALL, MASK_NO42};

  typedef struct {
    int          st;     // 0 OK, 1 SUSPECT, 2 FAULT
    int          pcnt;
    logic [W-1:0] voted;
    bit          mism;
    bit          err;
    logic [2:0]  fc;
    int          cnt;
  } mdl_t;

  mdl_t m [4];

  int checks   = 0;
  int failures = 0;

  logic         inj_en   = 1'b0;
  logic [W-1:0] inj_mask = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z.st = 0; z.pcnt = 0; z.voted = '0; z.mism = 0; z.err = 0; z.fc = '0; z.cnt = 0;
    return z;
  endfunction

  // One clock of the checker as described behaviourally: pairwise compare, vote, blame, filter.
  function automatic mdl_t model_step(input mdl_t s, input int k,
                                      input logic [W-1:0] c0, input logic [W-1:0] c1,
                                      input logic [W-1:0] c2, input bit v, input bit clr,
                                      input bit ie, input logic [W-1:0] im);
    mdl_t         n = s;
    logic [W-1:0] ch [3];
    logic [W-1:0] vt;
    logic [2:0]   bad;
    int           nch = int'(nch_c[k]);
    int           ndiff = 0;
    int           cmax;
    bit           raw;
    bit           enter = 0;
    ch[0] = c0; ch[1] = c1; ch[2] = c2;
    if (ie) ch[nch-1] = ch[nch-1] ^ im;
    for (int i = 0; i < nch; i++)
      for (int j = i + 1; j < nch; j++)
        if (((ch[i] ^ ch[j]) & mask_c[k]) != '0) ndiff++;
    raw = v && (ndiff > 0);
    if (nch == 2) begin
      vt  = ch[0];
      bad = 3'b011;
    end else begin
      for (int b = 0; b < W; b++)
        vt[b] = (int'(ch[0][b]) + int'(ch[1][b]) + int'(ch[2][b])) >= 2;
      if (ndiff == 3) bad = 3'b111;
      else for (int i = 0; i < 3; i++) bad[i] = (((ch[i] ^ vt) & mask_c[k]) != '0);
    end
    case (s.st)
      0: if (raw) begin
           if (filt_c[k] == 1) begin n.st = 2; enter = 1; end
           else begin n.st = 1; n.pcnt = 1; end
         end
      1: if (raw) begin
           n.pcnt = s.pcnt + 1;
           if (n.pcnt == int'(filt_c[k])) begin n.st = 2; enter = 1; end
         end else if (v) begin
           n.st = 0; n.pcnt = 0;
         end
      default: if (v && !raw) begin n.st = 0; n.pcnt = 0; end
    endcase
    n.voted = vt;
    n.mism  = raw;
    cmax    = (1 << cntw_c[k]) - 1;
    if (clr) begin
      n.st = 0; n.pcnt = 0; n.err = 0; n.fc = '0; n.cnt = 0;
    end else if (enter) begin
      n.err = 1;
      n.fc  = s.fc | bad;
      n.cnt = (s.cnt < cmax) ? s.cnt + 1 : s.cnt;
    end
    return n;
  endfunction

  task automatic cmp(input int k, input logic [W-1:0] vo, input logic mi, input logic er,
                     input logic [2:0] fc, input logic [7:0] ec, input logic [1:0] st);
    check($sformatf("d%0d.voted_out", k), 64'(vo), 64'(m[k].voted));
    check($sformatf("d%0d.mismatch", k), 64'(mi), 64'(m[k].mism));
    check($sformatf("d%0d.DLS_ERROR", k), 64'(er), 64'(m[k].err));
    check($sformatf("d%0d.fault_chan", k), 64'(fc), 64'(m[k].fc));
    check($sformatf("d%0d.err_count", k), 64'(ec), 64'(m[k].cnt));
    check($sformatf("d%0d.fsm_state", k), 64'(st), 64'(m[k].st));
  endtask

  task automatic compare_all();
    cmp(0, if_a.voted_out, if_a.mismatch, if_a.DLS_ERROR, 3'(if_a.fault_chan),
        8'(if_a.err_count), if_a.fsm_state);
    cmp(1, if_b.voted_out, if_b.mismatch, if_b.DLS_ERROR, 3'(if_b.fault_chan),
        8'(if_b.err_count), if_b.fsm_state);
    cmp(2, if_s.voted_out, if_s.mismatch, if_s.DLS_ERROR, 3'(if_s.fault_chan),
        8'(if_s.err_count), if_s.fsm_state);
    cmp(3, if_m.voted_out, if_m.mismatch, if_m.DLS_ERROR, 3'(if_m.fault_chan),
        8'(if_m.err_count), if_m.fsm_state);
  endtask

  task automatic drive(input logic [W-1:0] c0, input logic [W-1:0] c1, input logic [W-1:0] c2,
                       input bit v, input bit clr);
    if_a.ch_in = {c1, c0};      if_s.ch_in = {c1, c0};
    if_b.ch_in = {c2, c1, c0};  if_m.ch_in = {c2, c1, c0};
    if_a.ch_valid = v;   if_b.ch_valid = v;   if_s.ch_valid = v;   if_m.ch_valid = v;
    if_a.err_clear = clr; if_b.err_clear = clr; if_s.err_clear = clr; if_m.err_clear = clr;
`ifdef DLS_ERR_INJECT_EN
    if_a.inj_en = inj_en; if_b.inj_en = inj_en; if_s.inj_en = inj_en; if_m.inj_en = inj_en;
    if_a.inj_mask = inj_mask; if_b.inj_mask = inj_mask;
    if_s.inj_mask = inj_mask; if_m.inj_mask = inj_mask;
`endif
  endtask

  task automatic step(input logic [W-1:0] c0, input logic [W-1:0] c1, input logic [W-1:0] c2,
                      input bit v, input bit clr);
    drive(c0, c1, c2, v, clr);
    @(posedge HCLK);
    for (int k = 0; k < 4; k++)
      m[k] = model_step(m[k], k, c0, c1, c2, v, clr, inj_en, inj_mask);
    #1;
    compare_all();
  endtask

  function automatic int pick_bit();
    return ($urandom_range(0, 3) == 0) ? 42 : int'($urandom_range(0, 41));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] base;
    logic [W-1:0] b0, b5;
    int           bad_ch;

    base = 43'h0_AAAA_5555;
    b0   = base ^ 43'd1;          // RGB bit 0 flipped
    b5   = base ^ (43'd1 << 5);
    for (int k = 0; k < 4; k++) m[k] = mdl_zero();
    drive('0, '0, '0, 1'b0, 1'b0);

    // Reset values
    repeat (2) @(posedge HCLK);
    #1;
    compare_all();
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Matching bundles: no error, vote is channel 0 one cycle later
    step(base, base, base, 1, 0);
    check("t1.voted_eq_ch0", 64'(if_a.voted_out), 64'(base));
    check("t1.no_error", 64'(if_a.DLS_ERROR), 64'(0));

    // Single-cycle flip on ch1 with FILTER=1 confirms immediately
    step(base, b0, base, 1, 0);
    check("t2.mismatch", 64'(if_a.mismatch), 64'(1));
    check("t2.state_fault", 64'(if_a.fsm_state), 64'(2'b10));
    check("t2.fault_chan", 64'(if_a.fault_chan), 64'(2'b11));
    check("t2.err_count", 64'(if_a.err_count), 64'(1));
    step(base, base, base, 1, 0);
    check("t2.back_ok", 64'(if_a.fsm_state), 64'(2'b00));
    check("t2.sticky", 64'(if_a.DLS_ERROR), 64'(1));

    // FILTER=3: two mismatches only reach SUSPECT; three confirm and blame ch2
    step(base, base, b5, 1, 0);
    step(base, base, b5, 1, 0);
    check("t3.suspect", 64'(if_b.fsm_state), 64'(2'b01));
    check("t3.no_error", 64'(if_b.DLS_ERROR), 64'(0));
    step(base, base, base, 1, 0);
    repeat (3) step(base, base, b5, 1, 0);
    check("t3.fault", 64'(if_b.fsm_state), 64'(2'b10));
    check("t3.fault_chan", 64'(if_b.fault_chan), 64'(3'b100));
    check("t3.voted", 64'(if_b.voted_out), 64'(base));

    // Invalid cycles hold the persistence count
    step(base, base, base, 1, 1);
    step(base, base, b5, 1, 0);
    repeat (5) begin
      step(base, base, b5, 0, 0);
      check("t4.hold_suspect", 64'(if_b.fsm_state), 64'(2'b01));
    end
    step(base, base, b5, 1, 0);
    check("t4.still_suspect", 64'(if_b.fsm_state), 64'(2'b01));
    step(base, base, b5, 1, 0);
    check("t4.fault", 64'(if_b.fsm_state), 64'(2'b10));

    // Counter saturation at CNT_W=2, then clear beats a 6th confirmation
    step(base, base, base, 1, 1);
    repeat (5) begin
      step(base, b0, base, 1, 0);
      step(base, base, base, 1, 0);
    end
    check("t5.saturated", 64'(if_s.err_count), 64'(3));
    step(base, b0, base, 1, 1);
    check("t5.clr_err", 64'(if_s.DLS_ERROR), 64'(0));
    check("t5.clr_cnt", 64'(if_s.err_count), 64'(0));
    check("t5.clr_state", 64'(if_s.fsm_state), 64'(2'b00));

    // Filtering restarts from zero after a clear that lands mid-SUSPECT
    step(base, base, b5, 1, 0);
    step(base, base, b5, 1, 1);
    step(base, base, b5, 1, 0);
    step(base, base, b5, 1, 0);
    check("t5.restart_suspect", 64'(if_b.fsm_state), 64'(2'b01));

    // Asynchronous reset mid-SUSPECT
    HRESETn = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) m[k] = mdl_zero();
    compare_all();
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Random traffic with a persistently bad channel that changes every 8 cycles
    bad_ch = 3;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [63:0]  r;
      logic [W-1:0] c [3];
      bit           v, clr;
      if (cyc % 8 == 0) bad_ch = int'($urandom_range(0, 3));
      r = {$urandom(), $urandom()};
      for (int i = 0; i < 3; i++) begin
        c[i] = r[W-1:0];
        if (i == bad_ch || $urandom_range(0, 9) == 0) c[i] = c[i] ^ (43'd1 << pick_bit());
      end
      v   = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 99) < 2);
      step(c[0], c[1], c[2], v, clr);
    end

`ifdef DLS_ERR_INJECT_EN
    // Self-test injection on the last channel, with and without bit 42 compared
    step(base, base, base, 1, 1);
    inj_en   = 1'b1;
    inj_mask = 43'd1 << 42;
    repeat (3) step(base, base, base, 1, 0);
    check("t6.inj_fault", 64'(if_b.fsm_state), 64'(2'b10));
    check("t6.inj_chan", 64'(if_b.fault_chan), 64'(3'b100));
    check("t6.masked_no_mismatch", 64'(if_m.mismatch), 64'(0));
    check("t6.masked_ok", 64'(if_m.fsm_state), 64'(2'b00));
    check("t6.masked_vote", 64'(if_m.voted_out), 64'(base));
    inj_en   = 1'b0;
    inj_mask = '0;
    step(base, base, base, 1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
